// File: rtl/mux_4_to_1_rr_arbiter.sv
// Round-robin arbiter sequencing one shared 4:1 data mux between four requesters.
// Optional hold limit (forced rotation after MAX_HOLD grant cycles) enabled by MUX_HOLD_LIMIT_EN.
module mux_4_to_1_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter logic        OUT_IDLE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_lines,
    input  logic [3:0] input_lines,
    output logic [3:0] grant_lines,
    output logic [1:0] select_lines,
    output logic       out,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // A hold limit below 2 would rotate before the owner ever sees its data.
    if (MAX_HOLD < 2) begin : g_max_hold_too_small
    end

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic       out_q,   out_d;
    logic [1:0] last_q,  last_d;
    logic [2:0] idle_pick;
    logic [2:0] next_pick;
    logic [3:0] others;
    logic       rotate;

`ifdef MUX_HOLD_LIMIT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    // Returns {found, index}: first set bit of mask searching from last+1 with wrap.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = last + 2'(i + 1);
            if (mask[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        out_d     = out_q;
        last_d    = last_q;
        others    = req_lines & ~grant_q;
        idle_pick = rr_pick(req_lines, last_q);
        next_pick = rr_pick(others, sel_q);
        rotate    = 1'b0;
`ifdef MUX_HOLD_LIMIT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                out_d = OUT_IDLE;
                if (idle_pick[2]) begin
                    state_d = ST_GRANT;
                    grant_d = 4'(1) << idle_pick[1:0];
                    sel_d   = idle_pick[1:0];
`ifdef MUX_HOLD_LIMIT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_GRANT: begin
                out_d  = input_lines[sel_q];
                rotate = !req_lines[sel_q];
`ifdef MUX_HOLD_LIMIT_EN
                if (hold_q == HOLD_TOP) begin
                    if (others != 4'b0000) begin
                        rotate = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
                if (rotate) begin
                    last_d = sel_q;
`ifdef MUX_HOLD_LIMIT_EN
                    hold_d = '0;
`endif
                    if (next_pick[2]) begin
                        grant_d = 4'(1) << next_pick[1:0];
                        sel_d   = next_pick[1:0];
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 4'b0000;
                        out_d   = OUT_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                out_d   = OUT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            out_q   <= OUT_IDLE;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            last_q  <= last_d;
        end
    end

`ifdef MUX_HOLD_LIMIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign grant_lines  = grant_q;
    assign select_lines = sel_q;
    assign out          = out_q;
    assign busy         = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux_4_to_1_rr_arbiter.sv
// Scoreboard bench for mux_4_to_1_rr_arbiter: a behavioural model predicts each edge,
// predictions are queued at drive time and compared once the DUT has clocked.
module tb_mux_4_to_1_rr_arbiter;

    localparam int   MAX_HOLD = 8;
    localparam logic OUT_IDLE = 1'b0;

    logic       clk;
    logic       reset;
    logic [3:0] req_lines;
    logic [3:0] input_lines;
    logic [3:0] grant_lines;
    logic [1:0] select_lines;
    logic       out;
    logic       busy;

    mux_4_to_1_rr_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .OUT_IDLE (OUT_IDLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_lines    (req_lines),
        .input_lines  (input_lines),
        .grant_lines  (grant_lines),
        .select_lines (select_lines),
        .out          (out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       o;
        logic       b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state
    logic       m_busy;
    logic [3:0] m_grant;
    int         m_sel;
    logic       m_out;
    int         m_last;
    int         m_hold;

    logic       capture_en = 1'b0;
    logic [3:0] seen_grant = 4'b0000;
    logic [3:0] order_q[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] mask, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_edge();
        int         w;
        logic [3:0] other;
        logic       rot;
        if (reset) begin
            m_busy = 1'b0; m_grant = 4'b0000; m_sel = 0; m_out = OUT_IDLE; m_last = 3; m_hold = 0;
        end else if (!m_busy) begin
            m_out = OUT_IDLE;
            w = pick(req_lines, m_last);
            if (w >= 0) begin
                m_busy = 1'b1; m_sel = w; m_grant = 4'(1) << w; m_hold = 0;
            end
        end else begin
            m_out = input_lines[m_sel];
            other = req_lines & ~(4'(1) << m_sel);
            rot   = !req_lines[m_sel];
`ifdef MUX_HOLD_LIMIT_EN
            if (m_hold == MAX_HOLD - 1) begin
                if (other != 0) rot = 1'b1;
            end else begin
                m_hold++;
            end
`endif
            if (rot) begin
                m_last = m_sel;
                m_hold = 0;
                w = pick(other, m_sel);
                if (w >= 0) begin
                    m_sel = w; m_grant = 4'(1) << w;
                end else begin
                    m_busy = 1'b0; m_grant = 4'b0000; m_out = OUT_IDLE;
                end
            end
        end
    endfunction

    task automatic cycle();
        exp_t e;
        model_edge();
        e.grant = m_grant; e.sel = 2'(m_sel); e.o = m_out; e.b = m_busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("grant",  32'(grant_lines),  32'(e.grant));
            check("select", 32'(select_lines), 32'(e.sel));
            check("out",    32'(out),          32'(e.o));
            check("busy",   32'(busy),         32'(e.b));
        end
        if (capture_en && grant_lines != seen_grant && grant_lines != 4'b0000) begin
            order_q.push_back(grant_lines);
        end
        seen_grant = grant_lines;
    endtask

    logic [3:0] exp_order [5];
    int         owner;

    initial begin
        reset = 1'b1; req_lines = 4'b0000; input_lines = 4'b0000;
        m_busy = 1'b0; m_grant = 4'b0000; m_sel = 0; m_out = OUT_IDLE; m_last = 3; m_hold = 0;

        // reset state
        repeat (2) cycle();
        check("rst_grant", 32'(grant_lines), 32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        reset = 1'b0;
        cycle();

        // single requester: grant, data one cycle later, release to idle
        req_lines = 4'b0001; input_lines = 4'b0001;
        cycle();
        check("t2_grant", 32'(grant_lines), 32'h1);
        check("t2_out_first", 32'(out), 32'h0);
        cycle();
        check("t2_out", 32'(out), 32'h1);
        req_lines = 4'b0000;
        cycle();
        check("t2_idle_busy", 32'(busy), 32'h0);
        check("t2_idle_out",  32'(out),  32'h0);

        // all four requesting; each owner releases for one cycle after three grant cycles
        reset = 1'b1; cycle(); reset = 1'b0;
        capture_en = 1'b1;
        req_lines = 4'b1111; input_lines = 4'b1010;
        cycle();
        owner = 0;
        for (int r = 0; r < 5; r++) begin
            req_lines = 4'b1111;
            repeat (2) cycle();
            req_lines = 4'b1111 & ~(4'(1) << owner);
            input_lines = 4'($urandom_range(0, 15));
            cycle();
            check("t3_no_gap", 32'(busy), 32'h1);
            owner = (owner + 1) % 4;
        end
        capture_en = 1'b0;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        check("t3_order_len", 32'(order_q.size() >= 5), 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (i < order_q.size()) check("t3_order", 32'(order_q[i]), 32'(exp_order[i]));
        end
        req_lines = 4'b0000;
        repeat (2) cycle();

        // owner 2 releases with 0 and 3 waiting: 3 comes first after last=2
        req_lines = 4'b0100;
        cycle();
        check("t4_grant2", 32'(grant_lines), 32'h4);
        req_lines = 4'b1101;
        repeat (2) cycle();
        check("t4_no_preempt", 32'(grant_lines), 32'h4);
        req_lines = 4'b1001;
        cycle();
        check("t4_grant3", 32'(grant_lines), 32'h8);
        check("t4_sel3",   32'(select_lines), 32'h3);
        input_lines = 4'b1000;
        cycle();
        check("t4_out_hi", 32'(out), 32'h1);
        input_lines = 4'b0111;
        cycle();
        check("t4_out_lo", 32'(out), 32'h0);
        req_lines = 4'b0001;
        cycle();
        check("t4_grant0", 32'(grant_lines), 32'h1);
        req_lines = 4'b0000;
        repeat (2) cycle();

        // two requesters held continuously
        reset = 1'b1; cycle(); reset = 1'b0;
        req_lines = 4'b0011; input_lines = 4'b0010;
        cycle();
        repeat (8) cycle();
`ifdef MUX_HOLD_LIMIT_EN
        check("t5_rotated", 32'(grant_lines), 32'h2);
        repeat (8) cycle();
        check("t5_back", 32'(grant_lines), 32'h1);
        req_lines = 4'b0001;
        repeat (20) cycle();
        check("t5_single_kept", 32'(grant_lines), 32'h1);
`else
        repeat (12) cycle();
        check("t5_no_limit", 32'(grant_lines), 32'h1);
`endif
        req_lines = 4'b0000;
        repeat (2) cycle();

        // reset during grant, then re-grant one cycle after release
        req_lines = 4'b0100; input_lines = 4'b0100;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        check("t6_rst_grant", 32'(grant_lines), 32'h0);
        check("t6_rst_sel",   32'(select_lines), 32'h0);
        check("t6_rst_out",   32'(out), 32'h0);
        reset = 1'b0;
        cycle();
        check("t6_regrant", 32'(grant_lines), 32'h4);
        check("t6_sel",     32'(select_lines), 32'h2);

        // random traffic with occasional reset
        for (int n = 0; n < 300; n++) begin
            req_lines   = 4'($urandom_range(0, 15));
            input_lines = 4'($urandom_range(0, 15));
            reset       = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset = 1'b0; req_lines = 4'b0000;
        cycle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
